// File: rtl/l1ca_acq_scheduler.sv
// L1 C/A acquisition scheduler: sweeps enabled, untracked PRNs through the search
// engine, runs a confirmation search on each candidate and hands off confirmed detections.
module l1ca_acq_scheduler #(
  parameter int THRESH_W = 32,
  parameter int DOP_TOL  = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                run,
  input  logic                continuous,
  input  logic [31:0]         sv_mask,
  input  logic [31:0]         track_mask,
  input  logic [THRESH_W-1:0] threshold,
  output logic                search_start,
  output logic [5:0]          search_sv,
  input  logic                search_busy,
  input  logic [31:0]         search_acc,
  input  logic [11:0]         search_code,
  input  logic [4:0]          search_dop,
  output logic                det_valid,
  input  logic                det_ready,
  output logic [5:0]          det_sv,
  output logic [11:0]         det_code,
  output logic [4:0]          det_dop,
  output logic [31:0]         det_power,
  output logic                sweep_done,
  output logic [15:0]         sweep_count,
  output logic                active
);

  // state     | meaning
  // IDLE      | scheduling disabled, waiting for run
  // SELECT    | pick lowest pending PRN, or close the sweep
  // LAUNCH    | one-cycle start pulse to the engine
  // WAIT_ACK  | waiting for engine busy to rise
  // WAIT_DONE | waiting for engine busy to fall
  // EVAL      | judge engine result (first or confirmation pass)
  // EMIT      | detection offered until accepted
  typedef enum logic [2:0] {IDLE, SELECT, LAUNCH, WAIT_ACK, WAIT_DONE, EVAL, EMIT} state_t;

  localparam int CW = (THRESH_W > 32) ? THRESH_W : 32;

  state_t      state, state_nxt;
  logic [31:0] pending, pending_nxt;
  logic        pass, pass_nxt;
  logic [4:0]  cand_dop, cand_dop_nxt;
  logic [5:0]  sv_nxt;
  logic [5:0]  det_sv_nxt;
  logic [11:0] det_code_nxt;
  logic [4:0]  det_dop_nxt;
  logic [31:0] det_power_nxt;
  logic [15:0] sweep_count_nxt;

  logic [31:0]   avail;
  logic [31:0]   cur_bit;
  logic [4:0]    sel;
  logic [4:0]    dop_diff;
  logic [CW-1:0] acc_x, thr_x;
  logic          hit, dop_ok;

  assign avail    = pending & ~track_mask;
  assign cur_bit  = 32'd1 << (search_sv - 6'd1);
  assign acc_x    = CW'(search_acc);
  assign thr_x    = CW'(threshold);
  assign hit      = acc_x > thr_x;
  assign dop_diff = (search_dop >= cand_dop) ? (search_dop - cand_dop) : (cand_dop - search_dop);
  assign dop_ok   = {27'd0, dop_diff} <= 32'(DOP_TOL);

  assign search_start = (state == LAUNCH);
  assign det_valid    = (state == EMIT);
  assign active       = (state != IDLE);

  always_comb begin
    sel = '0;
    for (int i = 31; i >= 0; i--) begin
      if (avail[i]) sel = 5'(i);
    end
  end

  always_comb begin
    state_nxt       = state;
    pending_nxt     = pending;
    pass_nxt        = pass;
    cand_dop_nxt    = cand_dop;
    sv_nxt          = search_sv;
    det_sv_nxt      = det_sv;
    det_code_nxt    = det_code;
    det_dop_nxt     = det_dop;
    det_power_nxt   = det_power;
    sweep_count_nxt = sweep_count;
    sweep_done      = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          pending_nxt = sv_mask & ~track_mask;
          pass_nxt    = 1'b0;
          state_nxt   = SELECT;
        end
      end
      SELECT: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (|avail) begin
          sv_nxt    = 6'(sel) + 6'd1;
          state_nxt = LAUNCH;
        end else begin
          sweep_done      = 1'b1;
          sweep_count_nxt = sweep_count + 16'd1;
          if (continuous) pending_nxt = sv_mask & ~track_mask;
          else            state_nxt   = IDLE;
        end
      end
      LAUNCH:    state_nxt = WAIT_ACK;
      WAIT_ACK:  if (search_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!search_busy) state_nxt = EVAL;
      EVAL: begin
        // with run low the result is dropped and pending is left untouched
        if (!run) begin
          state_nxt = IDLE;
        end else if (!pass) begin
          if (hit) begin
            cand_dop_nxt = search_dop;
            pass_nxt     = 1'b1;
            state_nxt    = LAUNCH;
          end else begin
            pending_nxt = pending & ~cur_bit;
            state_nxt   = SELECT;
          end
        end else begin
          pending_nxt = pending & ~cur_bit;
          pass_nxt    = 1'b0;
          if (hit && dop_ok) begin
            det_sv_nxt    = search_sv;
            det_code_nxt  = search_code;
            det_dop_nxt   = search_dop;
            det_power_nxt = search_acc;
            state_nxt     = EMIT;
          end else begin
            state_nxt = SELECT;
          end
        end
      end
      EMIT:    if (det_ready) state_nxt = SELECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      pending     <= '0;
      pass        <= 1'b0;
      cand_dop    <= '0;
      search_sv   <= 6'd1;
      det_sv      <= '0;
      det_code    <= '0;
      det_dop     <= '0;
      det_power   <= '0;
      sweep_count <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      pass        <= pass_nxt;
      cand_dop    <= cand_dop_nxt;
      search_sv   <= sv_nxt;
      det_sv      <= det_sv_nxt;
      det_code    <= det_code_nxt;
      det_dop     <= det_dop_nxt;
      det_power   <= det_power_nxt;
      sweep_count <= sweep_count_nxt;
    end
  end

endmodule

// File: tb/tb_l1ca_acq_scheduler.sv
// Directed bench for l1ca_acq_scheduler with a behavioural search-engine model
// answering from a per-test response table.
module tb_l1ca_acq_scheduler;

  logic        clk;
  logic        nrst;
  logic        run;
  logic        continuous;
  logic [31:0] sv_mask;
  logic [31:0] track_mask;
  logic [31:0] threshold;
  logic        search_start;
  logic [5:0]  search_sv;
  logic        search_busy;
  logic [31:0] search_acc;
  logic [11:0] search_code;
  logic [4:0]  search_dop;
  logic        det_valid;
  logic        det_ready;
  logic [5:0]  det_sv;
  logic [11:0] det_code;
  logic [4:0]  det_dop;
  logic [31:0] det_power;
  logic        sweep_done;
  logic [15:0] sweep_count;
  logic        active;

  l1ca_acq_scheduler #(.THRESH_W(32), .DOP_TOL(1)) dut (
    .clk(clk), .nrst(nrst), .run(run), .continuous(continuous),
    .sv_mask(sv_mask), .track_mask(track_mask), .threshold(threshold),
    .search_start(search_start), .search_sv(search_sv), .search_busy(search_busy),
    .search_acc(search_acc), .search_code(search_code), .search_dop(search_dop),
    .det_valid(det_valid), .det_ready(det_ready), .det_sv(det_sv),
    .det_code(det_code), .det_dop(det_dop), .det_power(det_power),
    .sweep_done(sweep_done), .sweep_count(sweep_count), .active(active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // event counters kept by the monitor; tests compare against baselines
  int         n_start = 0;
  int         n_sweep = 0;
  int         n_detv  = 0;
  logic [5:0] sv_log [0:255];

  always @(negedge clk) begin
    if (search_start) begin
      sv_log[n_start % 256] <= search_sv;
      n_start <= n_start + 1;
    end
    if (sweep_done) n_sweep <= n_sweep + 1;
    if (det_valid)  n_detv  <= n_detv + 1;
  end

  // engine response table, indexed by search number since r_base
  logic [31:0] r_acc  [0:7];
  logic [4:0]  r_dop  [0:7];
  logic [11:0] r_code [0:7];
  int          r_base  = 0;
  int          eng_len = 4;

  initial begin
    int n_served;
    int k;
    n_served    = 0;
    search_busy = 1'b0;
    search_acc  = '0;
    search_code = '0;
    search_dop  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (n_start > n_served) begin
        k = n_served - r_base;
        if (k > 7) k = 7;
        if (k < 0) k = 0;
        n_served = n_served + 1;
        @(posedge clk);
        #1 search_busy = 1'b1;
        repeat (eng_len) @(posedge clk);
        #1;
        search_acc  = r_acc[k];
        search_code = r_code[k];
        search_dop  = r_dop[k];
        search_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    nrst       = 1'b0;
    run        = 1'b0;
    det_ready  = 1'b0;
    continuous = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic set_resp(input int i, input logic [31:0] acc, input logic [4:0] dop, input logic [11:0] code);
    r_acc[i]  = acc;
    r_dop[i]  = dop;
    r_code[i] = code;
  endtask

  task automatic fill_resp(input logic [31:0] acc, input logic [4:0] dop);
    for (int i = 0; i < 8; i++) set_resp(i, acc, dop, 12'(i));
  endtask

  task automatic start_run(input logic [31:0] svm, input logic [31:0] trk, input logic cont, input logic [31:0] thr);
    sv_mask    = svm;
    track_mask = trk;
    continuous = cont;
    threshold  = thr;
    r_base     = n_start;
    run        = 1'b1;
  endtask

  // waits for a sweep_done pulse, then drops run after the edge that consumed it
  task automatic wait_sweep(input int max_cyc);
    bit got;
    got = 1'b0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge clk);
      if (sweep_done) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL sweep_timeout: no sweep_done within %0d cycles, want pulse", max_cyc);
    end
    @(posedge clk);
    #1 run = 1'b0;
  endtask

  task automatic wait_det(input int max_cyc);
    bit got;
    got = 1'b0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge clk);
      if (det_valid) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL det_timeout: no det_valid within %0d cycles, want det_valid", max_cyc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (search_sv !== 6'd1)    begin n_fail++; $display("FAIL reset_search_sv: got %0d want 1", search_sv); end
    n_tests++; if (search_start !== 1'b0) begin n_fail++; $display("FAIL reset_search_start: got %b want 0", search_start); end
    n_tests++; if (det_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_det_valid: got %b want 0", det_valid); end
    n_tests++; if (sweep_count !== 16'd0) begin n_fail++; $display("FAIL reset_sweep_count: got %0d want 0", sweep_count); end
    n_tests++; if (active !== 1'b0)       begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
    n_tests++; if ({det_sv, det_code, det_dop, det_power, sweep_done} !== '0)
      begin n_fail++; $display("FAIL reset_det_regs: got sv=%0d code=%0d dop=%0d pwr=%0d sd=%b want all 0",
                              det_sv, det_code, det_dop, det_power, sweep_done); end
  endtask

  task automatic test_no_detect_sweep();
    int b_s, b_sw, b_d;
    do_reset();
    fill_resp(32'd100, 5'd3);
    b_s = n_start; b_sw = n_sweep; b_d = n_detv;
    start_run(32'h5, 32'h0, 1'b0, 32'd200);
    wait_sweep(300);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (n_start - b_s != 2)     begin n_fail++; $display("FAIL nd_starts: got %0d want 2", n_start - b_s); end
    n_tests++; if (sv_log[b_s] !== 6'd1)   begin n_fail++; $display("FAIL nd_first_sv: got %0d want 1", sv_log[b_s]); end
    n_tests++; if (sv_log[b_s+1] !== 6'd3) begin n_fail++; $display("FAIL nd_second_sv: got %0d want 3", sv_log[b_s+1]); end
    n_tests++; if (n_sweep - b_sw != 1)    begin n_fail++; $display("FAIL nd_sweep_pulses: got %0d want 1", n_sweep - b_sw); end
    n_tests++; if (sweep_count !== 16'd1)  begin n_fail++; $display("FAIL nd_sweep_count: got %0d want 1", sweep_count); end
    n_tests++; if (n_detv - b_d != 0)      begin n_fail++; $display("FAIL nd_det_valid: got %0d cycles want 0", n_detv - b_d); end
    n_tests++; if (active !== 1'b0)        begin n_fail++; $display("FAIL nd_idle: active got %b want 0", active); end
  endtask

  task automatic test_confirm_detect();
    int b_s, b_d;
    do_reset();
    fill_resp(32'd0, 5'd0);
    set_resp(0, 32'd500, 5'd10, 12'd111);
    set_resp(1, 32'd480, 5'd11, 12'd222);
    b_s = n_start; b_d = n_detv;
    start_run(32'h2, 32'h0, 1'b0, 32'd200);
    wait_det(300);
    #1;
    n_tests++; if (det_sv !== 6'd2)       begin n_fail++; $display("FAIL cd_det_sv: got %0d want 2", det_sv); end
    n_tests++; if (det_dop !== 5'd11)     begin n_fail++; $display("FAIL cd_det_dop: got %0d want 11", det_dop); end
    n_tests++; if (det_power !== 32'd480) begin n_fail++; $display("FAIL cd_det_power: got %0d want 480", det_power); end
    n_tests++; if (det_code !== 12'd222)  begin n_fail++; $display("FAIL cd_det_code: got %0d want 222", det_code); end
    n_tests++; if (n_start - b_s != 2)    begin n_fail++; $display("FAIL cd_starts: got %0d want 2", n_start - b_s); end
    n_tests++; if (sv_log[b_s] !== 6'd2 || sv_log[b_s+1] !== 6'd2)
      begin n_fail++; $display("FAIL cd_search_sv: got %0d,%0d want 2,2", sv_log[b_s], sv_log[b_s+1]); end
    #1 det_ready = 1'b1;
    wait_sweep(100);
    det_ready = 1'b0;
    n_tests++; if (n_detv - b_d != 1)     begin n_fail++; $display("FAIL cd_valid_cycles: got %0d want 1", n_detv - b_d); end
    n_tests++; if (sweep_count !== 16'd1) begin n_fail++; $display("FAIL cd_sweep_count: got %0d want 1", sweep_count); end
  endtask

  task automatic test_dop_reject();
    int b_s, b_d;
    do_reset();
    fill_resp(32'd0, 5'd0);
    set_resp(0, 32'd500, 5'd10, 12'd111);
    set_resp(1, 32'd480, 5'd13, 12'd222);
    b_s = n_start; b_d = n_detv;
    start_run(32'h2, 32'h0, 1'b0, 32'd200);
    wait_sweep(300);
    #1;
    n_tests++; if (n_start - b_s != 2)    begin n_fail++; $display("FAIL dr_starts: got %0d want 2", n_start - b_s); end
    n_tests++; if (n_detv - b_d != 0)     begin n_fail++; $display("FAIL dr_det_valid: got %0d cycles want 0", n_detv - b_d); end
    n_tests++; if (sweep_count !== 16'd1) begin n_fail++; $display("FAIL dr_sweep_count: got %0d want 1", sweep_count); end
  endtask

  task automatic test_thresh_equal();
    int b_s, b_d;
    do_reset();
    fill_resp(32'd200, 5'd4);
    b_s = n_start; b_d = n_detv;
    start_run(32'h1, 32'h0, 1'b0, 32'd200);
    wait_sweep(200);
    #1;
    n_tests++; if (n_start - b_s != 1) begin n_fail++; $display("FAIL eq_starts: got %0d want 1", n_start - b_s); end
    n_tests++; if (n_detv - b_d != 0)  begin n_fail++; $display("FAIL eq_det_valid: got %0d cycles want 0", n_detv - b_d); end
  endtask

  task automatic test_back_pressure();
    int  b_s, s0, cyc;
    bit  stable;
    do_reset();
    fill_resp(32'd10, 5'd0);
    set_resp(0, 32'd500, 5'd5, 12'd7);
    set_resp(1, 32'd600, 5'd6, 12'd8);
    b_s = n_start;
    start_run(32'h6, 32'h0, 1'b0, 32'd200);
    wait_det(300);
    #1;
    s0 = n_start;
    n_tests++; if (det_sv !== 6'd2 || det_code !== 12'd8 || det_dop !== 5'd6 || det_power !== 32'd600)
      begin n_fail++; $display("FAIL bp_det_fields: got sv=%0d code=%0d dop=%0d pwr=%0d want 2/8/6/600",
                              det_sv, det_code, det_dop, det_power); end
    n_tests++; if (s0 - b_s != 2) begin n_fail++; $display("FAIL bp_starts_before: got %0d want 2", s0 - b_s); end
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (det_valid !== 1'b1 || det_sv !== 6'd2 || det_code !== 12'd8 || det_dop !== 5'd6 ||
          det_power !== 32'd600 || search_start !== 1'b0) stable = 1'b0;
    end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL bp_hold: got change while stalled want stable"); end
    #2 det_ready = 1'b1;
    @(negedge clk);
    det_ready = 1'b0;
    n_tests++; if (det_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", det_valid); end
    cyc = 0;
    while (n_start == s0 && cyc < 20) begin
      @(negedge clk);
      #1 cyc++;
    end
    n_tests++; if (n_start == s0 || sv_log[s0] !== 6'd3)
      begin n_fail++; $display("FAIL bp_next_prn: got starts=%0d sv=%0d want PRN 3 launched", n_start - s0, sv_log[s0]); end
    wait_sweep(200);
    #1;
    n_tests++; if (sweep_count !== 16'd1) begin n_fail++; $display("FAIL bp_sweep_count: got %0d want 1", sweep_count); end
  endtask

  task automatic test_continuous();
    int b_s, seen, cyc;
    bit all_one;
    do_reset();
    fill_resp(32'd0, 5'd0);
    b_s = n_start;
    start_run(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'd200);
    seen = 0; cyc = 0;
    while (seen < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (sweep_done) seen++;
    end
    @(posedge clk);
    #1 run = 1'b0;
    continuous = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (seen != 3) begin n_fail++; $display("FAIL ct_sweeps_seen: got %0d want 3", seen); end
    n_tests++; if (n_start - b_s != 3) begin n_fail++; $display("FAIL ct_starts: got %0d want 3", n_start - b_s); end
    all_one = 1'b1;
    for (int i = 0; i < 3; i++) if (sv_log[b_s+i] !== 6'd1) all_one = 1'b0;
    n_tests++; if (!all_one) begin n_fail++; $display("FAIL ct_prn: got %0d,%0d,%0d want 1,1,1",
                                                     sv_log[b_s], sv_log[b_s+1], sv_log[b_s+2]); end
    n_tests++; if (sweep_count !== 16'd3) begin n_fail++; $display("FAIL ct_sweep_count: got %0d want 3", sweep_count); end
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL ct_idle: active got %b want 0", active); end
  endtask

  task automatic test_run_drop();
    int b_s, b_d, cyc;
    do_reset();
    eng_len = 6;
    fill_resp(32'd500, 5'd4);
    b_s = n_start; b_d = n_detv;
    start_run(32'h3, 32'h0, 1'b0, 32'd200);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (search_busy !== 1'b1 && cyc < 50);
    #2 run = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (search_busy !== 1'b0 && cyc < 50);
    n_tests++; if (search_busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_timeout: busy got %b want 0", search_busy); end
    @(negedge clk);
    n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL rd_active_eval: got %b want 1", active); end
    @(negedge clk);
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL rd_active_fall: got %b want 0", active); end
    repeat (20) @(negedge clk);
    #1;
    n_tests++; if (n_start - b_s != 1)    begin n_fail++; $display("FAIL rd_starts: got %0d want 1", n_start - b_s); end
    n_tests++; if (n_detv - b_d != 0)     begin n_fail++; $display("FAIL rd_det_valid: got %0d cycles want 0", n_detv - b_d); end
    n_tests++; if (sweep_count !== 16'd0) begin n_fail++; $display("FAIL rd_sweep_count: got %0d want 0", sweep_count); end
    eng_len = 4;
  endtask

  initial begin
    nrst       = 1'b0;
    run        = 1'b0;
    continuous = 1'b0;
    sv_mask    = '0;
    track_mask = '0;
    threshold  = '0;
    det_ready  = 1'b0;
    fill_resp(32'd0, 5'd0);
    test_reset();
    test_no_detect_sweep();
    test_confirm_detect();
    test_dop_reject();
    test_thresh_equal();
    test_back_pressure();
    test_continuous();
    test_run_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
